// File: rtl/sseg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: one digit per TICK_DIV-cycle slot, active-low drives.
// Define SSEG_BLANK_EN to blank the first BLANK_CYC cycles of every slot (anti-ghosting).
module sseg_scan_ctrl #(
  parameter int unsigned N_DIGITS  = 4,
  parameter int unsigned TICK_DIV  = 262144,
  parameter int unsigned BLANK_CYC = 1024,
  localparam int unsigned SW       = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1,
  localparam int unsigned CW       = $clog2(TICK_DIV)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [8*N_DIGITS-1:0] digits_in,
  input  logic [N_DIGITS-1:0]   digit_en,
  output logic [N_DIGITS-1:0]   an,
  output logic [7:0]            seg,
  output logic [SW-1:0]         slot_idx,
  output logic                  frame_tick
);

  if (N_DIGITS < 1 || N_DIGITS > 8) begin : gen_bad_n_digits
    $error("N_DIGITS must be in 1..8");
  end
  if (TICK_DIV < 2) begin : gen_bad_tick_div
    $error("TICK_DIV must be >= 2");
  end
  if (BLANK_CYC >= TICK_DIV) begin : gen_bad_blank_cyc
    $error("BLANK_CYC must be < TICK_DIV");
  end

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [SW-1:0]       slot_q, slot_d;
  logic [7:0]          pat_q, pat_cur;
  logic                en_q, en_cur;
  logic                slot_end, first_cyc, last_slot, drive;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic [7:0]          seg_q, seg_d;
  logic                frame_q;

  always_comb begin
    slot_end  = (cnt_q == CW'(TICK_DIV - 1));
    first_cyc = (cnt_q == '0);
    last_slot = (slot_q == SW'(N_DIGITS - 1));
    cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
    slot_d    = slot_q;
    if (slot_end) begin
      slot_d = last_slot ? '0 : slot_q + 1'b1;
    end

    // On cycle 0 use the live inputs directly so the capture and the drive agree.
    pat_cur = first_cyc ? digits_in[{slot_q, 3'b000} +: 8] : pat_q;
    en_cur  = first_cyc ? digit_en[slot_q] : en_q;

`ifdef SSEG_BLANK_EN
    drive = (32'(cnt_q) >= BLANK_CYC);
`else
    drive = 1'b1;
`endif

    an_d  = '1;
    seg_d = 8'hFF;
    if (drive && en_cur) begin
      an_d  = ~(N_DIGITS'(1) << slot_q);
      seg_d = ~pat_cur;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      slot_q  <= '0;
      pat_q   <= '0;
      en_q    <= 1'b0;
      an_q    <= '1;
      seg_q   <= 8'hFF;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      pat_q   <= pat_cur;
      en_q    <= en_cur;
      an_q    <= an_d;
      seg_q   <= seg_d;
      frame_q <= slot_end && last_slot;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign slot_idx   = slot_q;
  assign frame_tick = frame_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed bench for sseg_scan_ctrl with N_DIGITS=4, TICK_DIV=8, BLANK_CYC=2.
// Expectations follow SSEG_BLANK_EN the same way the design build does.
module tb_sseg_scan_ctrl;
  localparam int NDIG = 4;
  localparam int TD   = 8;
  localparam int BC   = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] digits_in;
  logic [3:0]  digit_en;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic [1:0]  slot_idx;
  logic        frame_tick;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] model_digits;

  sseg_scan_ctrl #(
    .N_DIGITS (NDIG),
    .TICK_DIV (TD),
    .BLANK_CYC(BC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .digits_in (digits_in),
    .digit_en  (digit_en),
    .an        (an),
    .seg       (seg),
    .slot_idx  (slot_idx),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  function automatic int blank_len();
`ifdef SSEG_BLANK_EN
    return BC;
`else
    return 0;
`endif
  endfunction

  // k counts cycles since reset release; outputs lag the slot state by one cycle.
  function automatic logic [3:0] exp_an(int k, logic [3:0] en);
    int s, ph;
    if (k == 0) return 4'hF;
    s  = ((k - 1) / TD) % NDIG;
    ph = (k - 1) % TD;
    if (ph < blank_len() || !en[s]) return 4'hF;
    return ~(4'b0001 << s);
  endfunction

  function automatic logic [7:0] exp_seg(int k, logic [3:0] en, logic [31:0] d);
    int s, ph;
    if (k == 0) return 8'hFF;
    s  = ((k - 1) / TD) % NDIG;
    ph = (k - 1) % TD;
    if (ph < blank_len() || !en[s]) return 8'hFF;
    return ~d[s*8 +: 8];
  endfunction

  function automatic logic [1:0] exp_slot(int k);
    return 2'((k / TD) % NDIG);
  endfunction

  function automatic logic exp_ft(int k);
    return (k > 0) && (k % (TD * NDIG) == 0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(int cycles);
    reset = 1'b1;
    repeat (cycles) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    digits_in    = 32'h065B4F66;
    model_digits = 32'h065B4F66;
    digit_en     = 4'hF;
    apply_reset(3);
    n_checks++;
    if (an !== 4'hF) begin
      n_fail++; $display("FAIL reset_an got %h expected %h", an, 4'hF);
    end
    n_checks++;
    if (seg !== 8'hFF) begin
      n_fail++; $display("FAIL reset_seg got %h expected %h", seg, 8'hFF);
    end
    n_checks++;
    if (frame_tick !== 1'b0) begin
      n_fail++; $display("FAIL reset_frame_tick got %b expected 0", frame_tick);
    end
    n_checks++;
    if (slot_idx !== 2'd0) begin
      n_fail++; $display("FAIL reset_slot_idx got %0d expected 0", slot_idx);
    end
  endtask

  task automatic run_scan(string name, logic [3:0] en, int ncyc, int exp_ticks);
    int ticks = 0;
    for (int k = 1; k <= ncyc; k++) begin
      tick();
      n_checks++;
      if (an !== exp_an(k, en)) begin
        n_fail++; $display("FAIL %s_an k=%0d got %b expected %b", name, k, an, exp_an(k, en));
      end
      n_checks++;
      if (seg !== exp_seg(k, en, model_digits)) begin
        n_fail++;
        $display("FAIL %s_seg k=%0d got %h expected %h", name, k, seg,
                 exp_seg(k, en, model_digits));
      end
      n_checks++;
      if (slot_idx !== exp_slot(k)) begin
        n_fail++;
        $display("FAIL %s_slot k=%0d got %0d expected %0d", name, k, slot_idx, exp_slot(k));
      end
      n_checks++;
      if (frame_tick !== exp_ft(k)) begin
        n_fail++;
        $display("FAIL %s_frame_tick k=%0d got %b expected %b", name, k, frame_tick, exp_ft(k));
      end
      n_checks++;
      if ($countones(~an) > 1) begin
        n_fail++; $display("FAIL %s_an_onehot k=%0d got %b expected <=1 low", name, k, an);
      end
      if (frame_tick === 1'b1) ticks++;
    end
    n_checks++;
    if (ticks != exp_ticks) begin
      n_fail++; $display("FAIL %s_tick_count got %0d expected %0d", name, ticks, exp_ticks);
    end
  endtask

  task automatic test_scan();
    tick();
    // First drive cycle of slot 0 (hand value; blanked when blanking is built in).
    n_checks++;
    if (an !== ((blank_len() > 0) ? 4'hF : 4'b1110)) begin
      n_fail++; $display("FAIL scan_first_an got %b expected 1110 or 1111 when blanked", an);
    end
    n_checks++;
    if (seg !== ((blank_len() > 0) ? 8'hFF : 8'h99)) begin
      n_fail++; $display("FAIL scan_first_seg got %h expected 99 or ff when blanked", seg);
    end
    // Restart cleanly so the table loop begins at cycle 0 of slot 0.
    apply_reset(1);
    run_scan("scan", 4'hF, 64, 2);
  endtask

  task automatic test_disable();
    digit_en = 4'b1011;
    apply_reset(1);
    run_scan("disable", 4'b1011, 64, 2);
    digit_en = 4'hF;
  endtask

  task automatic test_midslot_and_abort();
    digit_en = 4'hF;
    apply_reset(1);
    for (int k = 1; k <= 53; k++) begin
      tick();
      if (k == 41) model_digits[15:8] = 8'h7F;
      n_checks++;
      if (seg !== exp_seg(k, 4'hF, model_digits)) begin
        n_fail++;
        $display("FAIL midslot_seg k=%0d got %h expected %h", k, seg,
                 exp_seg(k, 4'hF, model_digits));
      end
      n_checks++;
      if (an !== exp_an(k, 4'hF)) begin
        n_fail++; $display("FAIL midslot_an k=%0d got %b expected %b", k, an, exp_an(k, 4'hF));
      end
      if (k == 14) begin
        n_checks++;
        if (seg !== 8'hB0) begin
          n_fail++; $display("FAIL midslot_hold got %h expected b0", seg);
        end
      end
      if (k == 44) begin
        n_checks++;
        if (seg !== 8'h80) begin
          n_fail++; $display("FAIL midslot_new got %h expected 80", seg);
        end
      end
      // Slot 1, cycle 3: change byte 1 while it is being shown.
      if (k == 11) digits_in[15:8] = 8'h7F;
    end
    // Now at slot 2, cycle 5: abort with a single reset edge.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (an !== 4'hF) begin
      n_fail++; $display("FAIL abort_an got %b expected 1111", an);
    end
    n_checks++;
    if (seg !== 8'hFF) begin
      n_fail++; $display("FAIL abort_seg got %h expected ff", seg);
    end
    n_checks++;
    if (slot_idx !== 2'd0) begin
      n_fail++; $display("FAIL abort_slot got %0d expected 0", slot_idx);
    end
    n_checks++;
    if (frame_tick !== 1'b0) begin
      n_fail++; $display("FAIL abort_frame_tick got %b expected 0", frame_tick);
    end
    run_scan("restart", 4'hF, 40, 1);
  endtask

  initial begin
    reset     = 1'b1;
    digits_in = '0;
    digit_en  = '0;
    test_reset();
    test_scan();
    test_disable();
    test_midslot_and_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
